axi_lite_regfile: RTL and testbench
===================================

# axi_lite_regfile

Parametrised AXI4-Lite slave register file, the next generation of our single-memory AXI-lite slave. Adds byte-lane write strobes, a configurable register count with SLVERR decode for unmapped addresses, per-register read-only masking backed by hardware status inputs, and a flat register output bus for driving control logic. Sits between the AXI-lite interconnect and a peripheral's control/status logic.

## Interface
Parameters:
- DATA_WD, 32, data width; 32 or 64 only
- ADDR_WD, 8, byte address width
- NUM_REGS, 16, number of registers; must be at most 2^(ADDR_WD-ADDR_LSB)
- RO_MASK, 0, NUM_REGS-bit mask; bit i set makes register i read-only
- RST_VAL, 0, DATA_WD-bit reset value of every read/write register
- Derived, not overridable: ADDR_LSB = $clog2(DATA_WD/8)

Ports:
- clk, in, 1, sole clock; all logic on its rising edge
- rst, in, 1, synchronous active-high reset; one clock, and reset is synchronous and active-high
- awaddr/awvalid/awready, in/in/out, ADDR_WD/1/1, write address channel
- wdata/wstrb/wvalid/wready, in/in/in/out, DATA_WD/DATA_WD/8/1/1, write data channel
- bresp/bvalid/bready, out/out/in, 2/1/1, write response channel
- araddr/arvalid/arready, in/in/out, ADDR_WD/1/1, read address channel
- rdata/rresp/rvalid/rready, out/out/out/in, DATA_WD/2/1/1, read data channel
- hw_in, in, NUM_REGS*DATA_WD, status values; slice i is the contents of read-only register i
- reg_q, out, NUM_REGS*DATA_WD, current value of every register; slice i is register i

## Operation
- Index = addr[ADDR_WD-1:ADDR_LSB]. Low ADDR_LSB bits are ignored; misaligned addresses are not an error.
- Index >= NUM_REGS: unmapped. Writes change nothing and return bresp=2'b10 (SLVERR). Reads return rdata=0 with rresp=2'b10.
- Write to a read-only index: nothing changes, bresp=SLVERR. Read of a read-only index returns hw_in slice with rresp=OKAY.
- Write to a read/write index: byte lane k is updated only if wstrb[k]=1. wstrb=0 is legal: nothing changes, bresp=OKAY.
- reg_q slice i: the register value for RW registers; the hw_in slice, combinationally, for RO registers.
- AW and W are independent. Each has a one-entry holding buffer (aw_full, w_full) that captures the address or data/strobe when it arrives alone.
- b_stall = bvalid && !bready. awready = !aw_full && !b_stall. wready = !w_full && !b_stall.
- commit = (awfire || aw_full) && (wfire || w_full). The address and data come from the live channel when it fires this cycle, otherwise from the buffer.
- On commit, the register update, bvalid<=1 and bresp are all registered at that edge, and both buffers are cleared.
- bvalid clears on bfire unless a commit happens in the same cycle, in which case it stays 1 with the new bresp.
- arready = !(rvalid && !rready). On arfire: rdata, rresp and rvalid<=1 are registered. rvalid clears on rfire without arfire. Simultaneous arfire and rfire keeps rvalid=1 with the new data.
- Read and write to the same register on the same edge: the read returns the old value.
- Read and write paths are fully independent; neither blocks the other.

## Timing
- Reset values while rst=1 at an edge: awready=1 and wready=1 from the next cycle, arready=1, bvalid=0, bresp=0, rvalid=0, rresp=0, rdata=0, buffers empty, every RW register = RST_VAL.
- Reset mid-transaction drops all buffered and outstanding transactions; no response is ever issued for them.
- Write latency: AW and W in the same cycle -> bvalid and the register update are visible the next cycle (1 cycle). Split arrival -> 1 cycle after the later channel fires.
- Write throughput: one write per cycle with bready held high. Back-pressure on bready deasserts awready and wready combinationally in the same cycle.
- Read latency: rvalid 1 cycle after arfire. Throughput is one read per cycle with rready held high.
- Payload stability: bresp, rdata and rresp stay stable while their valid is high and unacknowledged.

## Test plan
- Write 0xA5A5_1234 to index 3 with AW and W together and wstrb=0xF -> bvalid the next cycle, bresp=0, reg_q slice 3 = 0xA5A5_1234. A read of 0x0C then returns the same value with rresp=0.
- With register 2 = 0x1122_3344, write 0xFFFF_FFFF with wstrb=0x5 -> register 2 = 0x11FF_33FF.
- W arrives 3 cycles before AW -> wready=0 while w_full; bvalid 1 cycle after awfire; the data is committed to the AW address.
- Hold bready=0 for 4 cycles after a write -> awready=wready=0 throughout, bvalid and bresp stable. Release -> next write accepted in the same cycle as bfire and bvalid remains 1.
- With NUM_REGS=16: write to 0x40 -> SLVERR with no reg_q change. Read 0x44 -> rdata=0, rresp=2'b10. With RO_MASK bit 5 set and hw_in slice 5 = 0xDEAD_BEEF, a write to 0x14 -> SLVERR, and a read of 0x14 -> 0xDEAD_BEEF with OKAY.
- Back-to-back reads with rready=1 -> one rvalid per cycle. Assert rst during a pending write with AW buffered -> no bvalid afterwards and all registers = RST_VAL.

Source files
------------

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with byte strobes, SLVERR decode for unmapped or read-only
// writes, hardware-backed read-only registers and a flat register output bus.
module axi_lite_regfile #(
  parameter int unsigned         DATA_WD  = 32,
  parameter int unsigned         ADDR_WD  = 8,
  parameter int unsigned         NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter logic [DATA_WD-1:0]  RST_VAL  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WD-1:0]          awaddr,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [DATA_WD-1:0]          wdata,
  input  logic [DATA_WD/8-1:0]        wstrb,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  input  logic [ADDR_WD-1:0]          araddr,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [DATA_WD-1:0]          rdata,
  output logic [1:0]                  rresp,
  output logic                        rvalid,
  input  logic                        rready,
  input  logic [NUM_REGS*DATA_WD-1:0] hw_in,
  output logic [NUM_REGS*DATA_WD-1:0] reg_q
);

  localparam int unsigned ADDR_LSB    = $clog2(DATA_WD / 8);
  localparam int unsigned STRB_WD     = DATA_WD / 8;
  localparam int unsigned IDX_WD      = ADDR_WD - ADDR_LSB;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic               aw_full_q;
  logic [IDX_WD-1:0]  aw_idx_q;
  logic               w_full_q;
  logic [DATA_WD-1:0] w_data_q;
  logic [STRB_WD-1:0] w_strb_q;
  logic               bvalid_q;
  logic [1:0]         bresp_q;
  logic               rvalid_q;
  logic [DATA_WD-1:0] rdata_q;
  logic [1:0]         rresp_q;

  logic               b_stall;
  logic               aw_fire;
  logic               w_fire;
  logic               ar_fire;
  logic               commit;
  logic [IDX_WD-1:0]  wr_idx;
  logic [DATA_WD-1:0] wr_data;
  logic [STRB_WD-1:0] wr_strb;
  logic [IDX_WD-1:0]  rd_idx;
  logic [NUM_REGS-1:0] wr_sel;
  logic [NUM_REGS-1:0] rd_sel;
  logic               wr_err;
  logic               rd_err;
  logic [DATA_WD-1:0] rd_val;
  logic               unused_addr;

  assign unused_addr = ^{awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

  // Handshakes
  assign b_stall = bvalid_q && !bready;
  assign awready = !aw_full_q && !b_stall;
  assign wready  = !w_full_q && !b_stall;
  assign arready = !(rvalid_q && !rready);
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign ar_fire = arvalid && arready;
  assign commit  = (aw_fire || aw_full_q) && (w_fire || w_full_q);

  // A live channel that fires this cycle takes precedence over its buffer
  assign wr_idx  = aw_fire ? awaddr[ADDR_WD-1:ADDR_LSB] : aw_idx_q;
  assign wr_data = w_fire ? wdata : w_data_q;
  assign wr_strb = w_fire ? wstrb : w_strb_q;
  assign rd_idx  = araddr[ADDR_WD-1:ADDR_LSB];

  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = (wr_idx == IDX_WD'(i));
      rd_sel[i] = (rd_idx == IDX_WD'(i));
    end
  end

  assign wr_err = !(|wr_sel) || (|(wr_sel & RO_MASK));
  assign rd_err = !(|rd_sel);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel[i]) rd_val = reg_q[i*DATA_WD +: DATA_WD];
    end
  end

  // Write channel buffers and response
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (aw_fire) begin
          aw_full_q <= 1'b1;
          aw_idx_q  <= awaddr[ADDR_WD-1:ADDR_LSB];
        end
        if (w_fire) begin
          w_full_q <= 1'b1;
          w_data_q <= wdata;
          w_strb_q <= wstrb;
        end
        if (bready) bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_val;
      rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;

  // Read-only slots mirror hw_in; read/write slots hold byte-strobed storage
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign reg_q[i*DATA_WD +: DATA_WD] = hw_in[i*DATA_WD +: DATA_WD];
    end else begin : g_rw
      logic [DATA_WD-1:0] val_q;
      logic               unused_hw;

      assign unused_hw = ^hw_in[i*DATA_WD +: DATA_WD];

      always_ff @(posedge clk) begin
        if (rst) begin
          val_q <= RST_VAL;
        end else if (commit && wr_sel[i]) begin
          for (int k = 0; k < STRB_WD; k++) begin
            if (wr_strb[k]) val_q[8*k +: 8] <= wr_data[8*k +: 8];
          end
        end
      end

      assign reg_q[i*DATA_WD +: DATA_WD] = val_q;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: vector table of write/read-back pairs plus
// hand-written sequences for split arrival, back-pressure, back-to-back reads and reset.
module tb_axi_lite_regfile;

  localparam int unsigned NR = 16;
  localparam logic [31:0] RST = 32'h5A5A_0000;
  localparam logic [31:0] HW5 = 32'hDEAD_BEEF;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     awaddr;
  logic           awvalid;
  logic           awready;
  logic [31:0]    wdata;
  logic [3:0]     wstrb;
  logic           wvalid;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;
  logic [7:0]     araddr;
  logic           arvalid;
  logic           arready;
  logic [31:0]    rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready;
  logic [NR*32-1:0] hw_in;
  logic [NR*32-1:0] reg_q;

  axi_lite_regfile #(
    .DATA_WD (32),
    .ADDR_WD (8),
    .NUM_REGS(NR),
    .RO_MASK (16'h0020),
    .RST_VAL (RST)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready),
    .hw_in  (hw_in),
    .reg_q  (reg_q)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  typedef struct {
    logic [7:0]  awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [7:0]  araddr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          chk_idx;
    logic [31:0] reg_val;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slice(input int idx);
    return reg_q[idx*32 +: 32];
  endfunction

  // Scoreboard: pop on every response handshake
  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (exp_b.size() == 0) check("unexpected_b", 64'(bresp), 64'hBAD);
      else check("bresp", 64'(bresp), 64'(exp_b.pop_front()));
    end
    if (!rst && rvalid && rready) begin
      if (exp_r.size() == 0) check("unexpected_r", 64'({rdata, rresp}), 64'hBAD);
      else check("rdata_rresp", 64'({rdata, rresp}), 64'(exp_r.pop_front()));
    end
  end

  task automatic write_both(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] e);
    bit aw_done = 0;
    bit w_done  = 0;
    int n = 0;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    exp_b.push_back(e);
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge clk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      n++;
    end
    if (n >= 50) check("write_accept_timeout", 64'(n), 64'(0));
  endtask

  task automatic read_one(input logic [7:0] a, input logic [31:0] d, input logic [1:0] e);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    exp_r.push_back({d, e});
    while (arvalid && n < 50) begin
      @(negedge clk);
      @(posedge clk); #1;
      if (arready) arvalid = 1'b0;
      n++;
    end
    if (n >= 50) check("read_accept_timeout", 64'(n), 64'(0));
  endtask

  task automatic wait_b();
    int n = 0;
    while (exp_b.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_b.size() != 0) check("b_timeout", 64'(exp_b.size()), 64'(0));
  endtask

  task automatic wait_r();
    int n = 0;
    while (exp_r.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_r.size() != 0) check("r_timeout", 64'(exp_r.size()), 64'(0));
  endtask

  logic [7:0]  rd_addrs[4];
  logic [33:0] rd_exps[4];

  initial begin
    vecs[0] = '{8'h0C, 32'hA5A5_1234, 4'hF, 2'd0, 8'h0C, 32'hA5A5_1234, 2'd0, 3, 32'hA5A5_1234};
    vecs[1] = '{8'h08, 32'h1122_3344, 4'hF, 2'd0, 8'h08, 32'h1122_3344, 2'd0, 2, 32'h1122_3344};
    vecs[2] = '{8'h08, 32'hFFFF_FFFF, 4'h5, 2'd0, 8'h08, 32'h11FF_33FF, 2'd0, 2, 32'h11FF_33FF};
    vecs[3] = '{8'h09, 32'h0000_0000, 4'h2, 2'd0, 8'h0B, 32'h11FF_00FF, 2'd0, 2, 32'h11FF_00FF};
    vecs[4] = '{8'h04, 32'h1234_5678, 4'h0, 2'd0, 8'h04, RST,           2'd0, 1, RST};
    vecs[5] = '{8'h40, 32'hFFFF_FFFF, 4'hF, 2'd2, 8'h44, 32'h0,         2'd2, 0, RST};
    vecs[6] = '{8'h14, 32'hFFFF_FFFF, 4'hF, 2'd2, 8'h14, HW5,           2'd0, 5, HW5};
    vecs[7] = '{8'h3C, 32'h89AB_CDEF, 4'h8, 2'd0, 8'h3C, 32'h895A_0000, 2'd0, 15, 32'h895A_0000};
    vecs[8] = '{8'hFC, 32'h0000_0000, 4'hF, 2'd2, 8'h80, 32'h0,         2'd2, 15, 32'h895A_0000};
    vecs[9] = '{8'h00, 32'h0000_00FF, 4'h1, 2'd0, 8'h00, 32'h5A5A_00FF, 2'd0, 0, 32'h5A5A_00FF};

    for (int i = 0; i < NR; i++) hw_in[i*32 +: 32] = 32'h0101_0101 * (i + 7);
    hw_in[5*32 +: 32] = HW5;

    rst = 1'b1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 1'b1; araddr = '0; arvalid = 0; rready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_awready", 64'(awready), 64'(1));
    check("rst_wready",  64'(wready),  64'(1));
    check("rst_arready", 64'(arready), 64'(1));
    check("rst_bvalid",  64'(bvalid),  64'(0));
    check("rst_rvalid",  64'(rvalid),  64'(0));
    check("rst_bresp_rresp_rdata", 64'({bresp, rresp, rdata}), 64'(0));
    check("rst_reg0", 64'(slice(0)), 64'(RST));
    check("rst_reg5_hw", 64'(slice(5)), 64'(HW5));
    @(posedge clk); #1;

    // Vector table: write, check register, read back
    for (int i = 0; i < 10; i++) begin
      write_both(vecs[i].awaddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].bresp);
      wait_b();
      check($sformatf("vec%0d_reg_q", i), 64'(slice(vecs[i].chk_idx)), 64'(vecs[i].reg_val));
      read_one(vecs[i].araddr, vecs[i].rdata, vecs[i].rresp);
      wait_r();
    end

    // W arrives 3 cycles ahead of AW
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("early_w_wready", 64'(wready), 64'(1));
    @(posedge clk); #1 wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("w_full_wready", 64'(wready), 64'(0));
      check("w_full_no_bvalid", 64'(bvalid), 64'(0));
      @(posedge clk); #1;
    end
    awaddr = 8'h18; awvalid = 1'b1;
    exp_b.push_back(2'd0);
    @(negedge clk);
    check("late_aw_awready", 64'(awready), 64'(1));
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk);
    check("split_bvalid", 64'(bvalid), 64'(1));
    check("split_reg6", 64'(slice(6)), 64'(32'h0BAD_F00D));
    wait_b();

    // bready back-pressure with a second write waiting
    bready = 1'b0;
    write_both(8'h1C, 32'h0000_0001, 4'hF, 2'd0);
    awaddr = 8'h14; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    exp_b.push_back(2'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_awready", 64'(awready), 64'(0));
      check("stall_wready", 64'(wready), 64'(0));
      check("stall_bvalid", 64'(bvalid), 64'(1));
      check("stall_bresp", 64'(bresp), 64'(0));
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    check("release_awready", 64'(awready), 64'(1));
    check("release_wready", 64'(wready), 64'(1));
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("release_bvalid_held", 64'(bvalid), 64'(1));
    check("release_bresp_new", 64'(bresp), 64'(2));
    check("stall_reg7", 64'(slice(7)), 64'(1));
    wait_b();

    // Back-to-back reads
    rd_addrs[0] = 8'h0C; rd_exps[0] = {32'hA5A5_1234, 2'd0};
    rd_addrs[1] = 8'h08; rd_exps[1] = {32'h11FF_00FF, 2'd0};
    rd_addrs[2] = 8'h14; rd_exps[2] = {HW5, 2'd0};
    rd_addrs[3] = 8'h44; rd_exps[3] = {32'h0, 2'd2};
    arvalid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      araddr = rd_addrs[j];
      exp_r.push_back(rd_exps[j]);
      @(negedge clk);
      check("b2b_arready", 64'(arready), 64'(1));
      if (j > 0) check("b2b_rvalid", 64'(rvalid), 64'(1));
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    @(negedge clk);
    check("b2b_rvalid_last", 64'(rvalid), 64'(1));
    wait_r();

    // Read and write of the same register on the same edge returns the old value
    awaddr = 8'h0C; wdata = 32'h600D_0003; wstrb = 4'hF; araddr = 8'h0C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    exp_b.push_back(2'd0);
    exp_r.push_back({32'hA5A5_1234, 2'd0});
    @(negedge clk);
    check("same_edge_ready", 64'({awready, wready, arready}), 64'(3'b111));
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wait_b();
    wait_r();
    read_one(8'h0C, 32'h600D_0003, 2'd0);
    wait_r();

    // Reset with AW buffered: the pending write must never complete
    awaddr = 8'h00; awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 awvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wdata = 32'h0000_0077; wstrb = 4'hF; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_bvalid", 64'(bvalid), 64'(0));
      @(posedge clk); #1 wvalid = 1'b0;
    end
    for (int i = 0; i < NR; i++) begin
      check($sformatf("post_rst_reg%0d", i), 64'(slice(i)), 64'((i == 5) ? HW5 : RST));
    end

    check("b_queue_empty", 64'(exp_b.size()), 64'(0));
    check("r_queue_empty", 64'(exp_r.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
